// File: rtl/i2c_read_rdata_if.sv
// i2c_read_rdata_if: request, I2C line and status signals of the register-read master.
interface i2c_read_rdata_if;
    logic        GO;
    logic [7:0]  SLAVE_ADDRESS;
    logic [15:0] POINTER;
    logic        SDAI;
    logic        SDAO;
    logic        SCLO;
    logic        END_OK;
    logic        ACK_OK;
    logic [15:0] RDATA;
    logic [7:0]  ST;
    modport master (
        input  GO, SLAVE_ADDRESS, POINTER, SDAI,
        output SDAO, SCLO, END_OK, ACK_OK, RDATA, ST
    );
    modport slave (
        output GO, SLAVE_ADDRESS, POINTER, SDAI,
        input  SDAO, SCLO, END_OK, ACK_OK, RDATA, ST
    );
endinterface

// File: rtl/i2c_read_rdata.sv
// i2c_read_rdata: I2C master doing pointer write, repeated START and 16-bit read.
// Define I2C_READ_NACK_ABORT_EN to jump to STOP right after any slave NACK.
module i2c_read_rdata (
    input  logic             PT_CK,
    input  logic             RESET_N,
    i2c_read_rdata_if.master bus
);
    typedef enum logic [2:0] {IDLE, ARM, START, XFER, RSTART, ABORT, STOP} state_t;
    state_t      st;
    logic [1:0]  ph, cnt;
    logic [3:0]  bi;
    logic [2:0]  by;
    logic [15:0] sh, rdata;
    logic        sdao, sclo, end_ok, ack_ok, nack, abort;

    // Bytes 0-3 are master-driven (address/pointer/address), 4-5 are slave data.
    function automatic logic bit_val(input logic [2:0] b, input logic [3:0] i,
                                     input logic [6:0] a, input logic [15:0] p);
        logic [7:0] d;
        d = b == 3'd0 ? {a, 1'b0} : b == 3'd1 ? p[15:8] : b == 3'd2 ? p[7:0] :
            b == 3'd3 ? {a, 1'b1} : 8'hff;
        return i == 4'd8 ? b != 3'd4 : d[3'(4'd7 - i)];
    endfunction

`ifdef I2C_READ_NACK_ABORT_EN
    assign abort = bi == 4'd8 && by < 3'd4 && bus.SDAI;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge PT_CK or negedge RESET_N) begin
        if (!RESET_N) begin
            st <= IDLE;
            sdao <= 1'b1;
            sclo <= 1'b1;
            end_ok <= 1'b1;
            ack_ok <= 1'b0;
            rdata <= '0;
            sh <= '0;
            bi <= '0;
            by <= '0;
            ph <= '0;
            cnt <= '0;
            nack <= 1'b0;
        end else begin
            case (st)
                IDLE: if (bus.GO) st <= ARM;
                ARM: if (!bus.GO) begin
                    st <= START;
                    end_ok <= 1'b0;
                    ack_ok <= 1'b0;
                    nack <= 1'b0;
                    sdao <= 1'b0;
                    cnt <= '0;
                end
                START: if (cnt == 2'd0) begin
                    sclo <= 1'b0;
                    cnt <= 2'd1;
                end else begin
                    st <= XFER;
                    by <= '0;
                    bi <= '0;
                    ph <= '0;
                    sdao <= bit_val(3'd0, 4'd0, bus.SLAVE_ADDRESS[7:1], bus.POINTER);
                end
                XFER: if (ph != 2'd2) begin
                    ph <= ph + 2'd1;
                    sclo <= 1'b1;
                end else begin
                    ph <= '0;
                    sclo <= 1'b0;
                    if (bi < 4'd8 && by > 3'd3) sh <= {sh[14:0], bus.SDAI};
                    if (bi == 4'd8 && by < 3'd4 && bus.SDAI) nack <= 1'b1;
                    if (bi != 4'd8) begin
                        bi <= bi + 4'd1;
                        sdao <= bit_val(by, bi + 4'd1, bus.SLAVE_ADDRESS[7:1], bus.POINTER);
                    end else if (abort) begin
                        st <= ABORT;
                    end else if (by == 3'd2) begin
                        st <= RSTART;
                        sdao <= 1'b1;
                        cnt <= '0;
                    end else if (by == 3'd5) begin
                        st <= STOP;
                        sdao <= 1'b0;
                        cnt <= '0;
                        ack_ok <= !nack;
                        if (!nack) rdata <= sh;
                    end else begin
                        by <= by + 3'd1;
                        bi <= '0;
                        sdao <= bit_val(by + 3'd1, 4'd0, bus.SLAVE_ADDRESS[7:1], bus.POINTER);
                    end
                end
                RSTART: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd0) sclo <= 1'b1;
                    if (cnt == 2'd1) sdao <= 1'b0;
                    if (cnt == 2'd2) sclo <= 1'b0;
                    if (cnt == 2'd3) begin
                        st <= XFER;
                        by <= 3'd3;
                        bi <= '0;
                        sdao <= bit_val(3'd3, 4'd0, bus.SLAVE_ADDRESS[7:1], bus.POINTER);
                    end
                end
                // One SCL-low cycle after the NACK slot before the STOP sequence.
                ABORT: begin
                    st <= STOP;
                    sdao <= 1'b0;
                    cnt <= '0;
                end
                STOP: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd0) sclo <= 1'b1;
                    if (cnt == 2'd1) sdao <= 1'b1;
                    if (cnt == 2'd2) begin
                        st <= IDLE;
                        end_ok <= 1'b1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.SDAO = sdao;
    assign bus.SCLO = sclo;
    assign bus.END_OK = end_ok;
    assign bus.ACK_OK = ack_ok;
    assign bus.RDATA = rdata;
    assign bus.ST = {5'd0, st};
endmodule

// File: tb/tb_i2c_read_rdata.sv
// tb_i2c_read_rdata: directed reads against a wired-AND slave model and a bus monitor.
module tb_i2c_read_rdata;
    logic PT_CK = 1'b0;
    logic RESET_N = 1'b0;
    int total = 0;
    int bad = 0;

    i2c_read_rdata_if b ();
    i2c_read_rdata dut (.PT_CK(PT_CK), .RESET_N(RESET_N), .bus(b));

    always #5 PT_CK = ~PT_CK;

    logic       drv = 1'b1;
    logic [7:0] sl_dat [2];
    int         nak_byte = -1;
    assign b.SDAI = b.SDAO & drv;

    logic [7:0] rx [8];
    logic       ak [8];
    logic [7:0] sh8 = '0;
    int   bn = 0, bitn = 0, n_st = 0, n_sp = 0, lo = 0, viol = 0;
    logic fresh = 1'b0, p_scl = 1'b1, p_sda = 1'b1, p_sdao = 1'b1, p_end = 1'b1;

    // Bits are taken on SCL falling (value held while high); START/STOP are SDA edges with SCL high.
    always @(negedge PT_CK) begin
        logic sda;
        sda = b.SDAO & drv;
        if (!RESET_N) begin
            bn = 0;
            bitn = 0;
            fresh = 1'b0;
            drv = 1'b1;
            p_scl = 1'b1;
            p_sda = 1'b1;
            p_sdao = 1'b1;
            p_end = 1'b1;
        end else begin
            if (p_end && !b.END_OK) begin
                bn = 0;
                bitn = 0;
                n_st = 0;
                n_sp = 0;
                lo = 0;
                viol = 0;
                foreach (rx[i]) begin
                    rx[i] = '0;
                    ak[i] = 1'b0;
                end
            end
            if (!b.END_OK) lo++;
            if (b.SDAO != p_sdao && b.SCLO && !p_scl) viol++;
            if (p_scl && b.SCLO && p_sda && !sda) begin
                n_st++;
                fresh = 1'b1;
                bitn = 0;
            end else if (p_scl && b.SCLO && !p_sda && sda) begin
                n_sp++;
            end else if (p_scl && !b.SCLO) begin
                if (fresh) fresh = 1'b0;
                else begin
                    if (bitn < 8) sh8 = {sh8[6:0], p_sda};
                    else begin
                        rx[bn] = sh8;
                        ak[bn] = p_sda;
                    end
                    bitn++;
                    if (bitn == 9) begin
                        bitn = 0;
                        bn++;
                    end
                end
                drv = (bn == 4 || bn == 5) && bitn < 8 ? sl_dat[bn-4][7-bitn] :
                      bn < 4 && bitn == 8 ? (bn == nak_byte) : 1'b1;
            end
            p_scl = b.SCLO;
            p_sda = sda;
            p_sdao = b.SDAO;
            p_end = b.END_OK;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic go_read(input int hi, input bit pulse);
        int n;
        @(negedge PT_CK);
        b.GO = 1'b1;
        repeat (hi) @(negedge PT_CK);
        if (hi > 10) chk("go_held_idle", 32'(b.END_OK), 1);
        b.GO = 1'b0;
        n = 0;
        while (b.END_OK && n < 10) begin
            @(negedge PT_CK);
            n++;
        end
        if (pulse) begin
            repeat (30) @(negedge PT_CK);
            b.GO = 1'b1;
            repeat (3) @(negedge PT_CK);
            b.GO = 1'b0;
        end
        n = 0;
        while (!b.END_OK && n < 400) begin
            @(negedge PT_CK);
            n++;
        end
        chk("end_ok_back", 32'(b.END_OK), 1);
    endtask

    task automatic chk_read(input logic [7:0] b0, b1, b2, b3, input logic [15:0] rd);
        chk("dur", lo, 171);
        chk("wr_addr", 32'(rx[0]), 32'(b0));
        chk("ptr_hi", 32'(rx[1]), 32'(b1));
        chk("ptr_lo", 32'(rx[2]), 32'(b2));
        chk("rd_addr", 32'(rx[3]), 32'(b3));
        chk("data0", 32'(rx[4]), 32'(rd[15:8]));
        chk("data1", 32'(rx[5]), 32'(rd[7:0]));
        chk("m_ack", 32'(ak[4]), 0);
        chk("m_nack", 32'(ak[5]), 1);
        chk("rdata", 32'(b.RDATA), 32'(rd));
        chk("ack_ok", 32'(b.ACK_OK), 1);
        chk("starts", n_st, 2);
        chk("stops", n_sp, 1);
        chk("sda_on_scl_rise", viol, 0);
    endtask

    initial begin
        int n;
        b.GO = 1'b0;
        b.SLAVE_ADDRESS = 8'h20;
        b.POINTER = 16'h3000;
        sl_dat[0] = 8'hA5;
        sl_dat[1] = 8'h3C;
        repeat (3) @(negedge PT_CK);
        chk("rst_st", 32'(b.ST), 0);
        chk("rst_sdao", 32'(b.SDAO), 1);
        chk("rst_sclo", 32'(b.SCLO), 1);
        chk("rst_end_ok", 32'(b.END_OK), 1);
        chk("rst_ack_ok", 32'(b.ACK_OK), 0);
        chk("rst_rdata", 32'(b.RDATA), 0);
        RESET_N = 1'b1;
        repeat (3) @(negedge PT_CK);
        chk("idle_no_go", 32'(b.END_OK), 1);

        go_read(2, 1'b0);
        chk_read(8'h20, 8'h30, 8'h00, 8'h21, 16'hA53C);

        nak_byte = 1;
        sl_dat[0] = 8'h11;
        sl_dat[1] = 8'h22;
        go_read(2, 1'b0);
`ifdef I2C_READ_NACK_ABORT_EN
        chk("nack_dur", lo, 60);
        chk("nack_stops", n_sp, 1);
`else
        chk("nack_dur", lo, 171);
`endif
        chk("nack_seen", 32'(ak[1]), 1);
        chk("nack_ack_ok", 32'(b.ACK_OK), 0);
        chk("nack_rdata", 32'(b.RDATA), 32'hA53C);

        nak_byte = -1;
        b.SLAVE_ADDRESS = 8'hA7;
        b.POINTER = 16'h5A81;
        sl_dat[0] = 8'h00;
        sl_dat[1] = 8'hFF;
        go_read(50, 1'b1);
        chk_read(8'hA6, 8'h5A, 8'h81, 8'hA7, 16'h00FF);
        repeat (20) @(negedge PT_CK);
        chk("no_retrigger", 32'(b.END_OK), 1);

        b.SLAVE_ADDRESS = 8'h20;
        b.POINTER = 16'h3000;
        sl_dat[0] = 8'h12;
        sl_dat[1] = 8'h34;
        @(negedge PT_CK);
        b.GO = 1'b1;
        @(negedge PT_CK);
        b.GO = 1'b0;
        n = 0;
        while (bn != 5 && n < 300) begin
            @(negedge PT_CK);
            n++;
        end
        chk("reach_byte5", bn, 5);
        repeat (6) @(negedge PT_CK);
        #2 RESET_N = 1'b0;
        #1;
        chk("mid_rst_sdao", 32'(b.SDAO), 1);
        chk("mid_rst_sclo", 32'(b.SCLO), 1);
        chk("mid_rst_end_ok", 32'(b.END_OK), 1);
        chk("mid_rst_rdata", 32'(b.RDATA), 0);
        chk("mid_rst_ack_ok", 32'(b.ACK_OK), 0);
        chk("mid_rst_st", 32'(b.ST), 0);
        repeat (2) @(negedge PT_CK);
        RESET_N = 1'b1;
        repeat (10) @(negedge PT_CK);
        chk("post_rst_idle", 32'(b.END_OK), 1);
        sl_dat[0] = 8'h5E;
        sl_dat[1] = 8'hC1;
        go_read(2, 1'b0);
        chk_read(8'h20, 8'h30, 8'h00, 8'h21, 16'h5EC1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
